// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control/datapath boundary.
package mips_pkg;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_HOLD   = 2'b11
  } pcsrc_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_BNE   = 2'b11
  } aluop_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

endpackage

// File: rtl/mips_pc_ir_unit_if.sv
// Control, memory and datapath signals between the FSM side and the PC/IR stage.
interface mips_pc_ir_unit_if
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
);
  logic             PCWriteCond;
  logic             PCWrite;
  logic             IRWrite;
  logic             IorD;
  pcsrc_e           PCSource;
  aluop_e           ALUOp;
  logic [WIDTH-1:0] mem_rdata;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;

  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] instr;
  logic [5:0]       op;
  logic [WIDTH-1:0] mdr;
  logic [WIDTH-1:0] reg_a;
  logic [WIDTH-1:0] reg_b;
  logic [WIDTH-1:0] alu_out;
  logic             pc_en;
  logic             pc_misaligned;
  logic [31:0]      instr_count;

  modport master (
    output PCWriteCond, PCWrite, IRWrite, IorD, PCSource, ALUOp,
    output mem_rdata, alu_result, alu_zero, rd1, rd2,
    input  pc, mem_addr, instr, op, mdr, reg_a, reg_b, alu_out,
    input  pc_en, pc_misaligned, instr_count
  );

  modport slave (
    input  PCWriteCond, PCWrite, IRWrite, IorD, PCSource, ALUOp,
    input  mem_rdata, alu_result, alu_zero, rd1, rd2,
    output pc, mem_addr, instr, op, mdr, reg_a, reg_b, alu_out,
    output pc_en, pc_misaligned, instr_count
  );
endinterface

// File: rtl/mips_en_reg.sv
// Register with synchronous active-high reset and load enable.
module mips_en_reg #(
  parameter int unsigned          WIDTH     = 32,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)     q <= RESET_VAL;
    else if (en) q <= d;
  end
endmodule

// File: rtl/mips_pc_ir_unit.sv
// Multicycle MIPS state-holding stage: PC, IR, MDR, A, B, ALUOut, branch resolve,
// memory address mux and a saturating instruction-fetch counter.
module mips_pc_ir_unit
  import mips_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  mips_pc_ir_unit_if.slave bus
);
  logic             w_take;
  logic             w_pc_en;
  logic             w_mis_set;
  logic             w_cnt_en;
  logic [WIDTH-1:0] w_next_pc;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_instr;
  logic [WIDTH-1:0] r_alu_out;
  logic [31:0]      r_count;
  logic             r_mis;

  assign w_take  = (bus.ALUOp == ALUOP_BNE) ? ~bus.alu_zero : bus.alu_zero;
  assign w_pc_en = bus.PCWrite | (bus.PCWriteCond & w_take);

  // Jump target concatenation fixes the datapath at 32 bits.
  always_comb begin
    w_next_pc = r_pc;
    case (bus.PCSource)
      PCSRC_ALU:    w_next_pc = bus.alu_result;
      PCSRC_ALUOUT: w_next_pc = r_alu_out;
      PCSRC_JUMP:   w_next_pc = {r_pc[31:28], r_instr[25:0], 2'b00};
      PCSRC_HOLD:   w_next_pc = r_pc;
      default:      w_next_pc = r_pc;
    endcase
  end

  assign w_mis_set = w_pc_en & (w_next_pc[1:0] != 2'b00);
  assign w_cnt_en  = bus.IRWrite & ~(&r_count);

  mips_en_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_PC)) u_pc (
    .clk(clk), .rst(rst), .en(w_pc_en), .d(w_next_pc), .q(r_pc)
  );
  mips_en_reg #(.WIDTH(WIDTH), .RESET_VAL('0)) u_ir (
    .clk(clk), .rst(rst), .en(bus.IRWrite), .d(bus.mem_rdata), .q(r_instr)
  );
  mips_en_reg #(.WIDTH(WIDTH), .RESET_VAL('0)) u_mdr (
    .clk(clk), .rst(rst), .en(1'b1), .d(bus.mem_rdata), .q(bus.mdr)
  );
  mips_en_reg #(.WIDTH(WIDTH), .RESET_VAL('0)) u_a (
    .clk(clk), .rst(rst), .en(1'b1), .d(bus.rd1), .q(bus.reg_a)
  );
  mips_en_reg #(.WIDTH(WIDTH), .RESET_VAL('0)) u_b (
    .clk(clk), .rst(rst), .en(1'b1), .d(bus.rd2), .q(bus.reg_b)
  );
  mips_en_reg #(.WIDTH(WIDTH), .RESET_VAL('0)) u_alu_out (
    .clk(clk), .rst(rst), .en(1'b1), .d(bus.alu_result), .q(r_alu_out)
  );
  mips_en_reg #(.WIDTH(32), .RESET_VAL('0)) u_count (
    .clk(clk), .rst(rst), .en(w_cnt_en), .d(r_count + 32'd1), .q(r_count)
  );
  // Sticky flag: once set only reset clears it.
  mips_en_reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_mis (
    .clk(clk), .rst(rst), .en(w_mis_set), .d(1'b1), .q(r_mis)
  );

  assign bus.pc            = r_pc;
  assign bus.instr         = r_instr;
  assign bus.alu_out       = r_alu_out;
  assign bus.op            = r_instr[31:26];
  assign bus.mem_addr      = bus.IorD ? r_alu_out : r_pc;
  assign bus.pc_en         = w_pc_en;
  assign bus.pc_misaligned = r_mis;
  assign bus.instr_count   = r_count;
endmodule

// File: tb/tb_mips_pc_ir_unit.sv
// Scoreboard bench for mips_pc_ir_unit: directed scenarios then randomized cycles.
module tb_mips_pc_ir_unit;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mips_pc_ir_unit_if #(.WIDTH(32)) bus ();

  mips_pc_ir_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  typedef struct {
    logic [31:0] pc, instr, mdr, a, b, ao, cnt, maddr;
    logic        mis, pen;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  logic [31:0] m_pc = 'x, m_instr = 'x, m_mdr = 'x, m_a = 'x, m_b = 'x, m_ao = 'x, m_cnt = 'x;
  logic        m_mis = 1'bx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the model's view of it.
  task automatic drive(input logic r, input logic pcwc, input logic pcw, input logic irw,
                       input logic iord, input logic [1:0] psrc, input logic [1:0] aop,
                       input logic [31:0] rdata, input logic [31:0] ares, input logic z);
    logic [31:0] r1, r2, npc;
    logic        take, pen;
    exp_t        e;
    @(negedge clk);
    r1 = $urandom;
    r2 = $urandom;
    rst = r;
    bus.PCWriteCond = pcwc; bus.PCWrite = pcw; bus.IRWrite = irw; bus.IorD = iord;
    bus.PCSource = pcsrc_e'(psrc); bus.ALUOp = aluop_e'(aop);
    bus.mem_rdata = rdata; bus.alu_result = ares; bus.alu_zero = z;
    bus.rd1 = r1; bus.rd2 = r2;
    take = (aop == 2'b11) ? !z : z;
    pen  = pcw || (pcwc && take);
    if (psrc == 2'd0)      npc = ares;
    else if (psrc == 2'd1) npc = m_ao;
    else if (psrc == 2'd2) npc = {m_pc[31:28], m_instr[25:0], 2'b00};
    else                   npc = m_pc;
    e.pen = pen;
    e.maddr = iord ? m_ao : m_pc;
    if (r) begin
      m_pc = 0; m_instr = 0; m_mdr = 0; m_a = 0; m_b = 0; m_ao = 0; m_cnt = 0; m_mis = 0;
    end else begin
      if (pen) begin
        m_pc = npc;
        if (npc % 4 != 0) m_mis = 1'b1;
      end
      if (irw) begin
        m_instr = rdata;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      end
      m_mdr = rdata; m_a = r1; m_b = r2; m_ao = ares;
    end
    e.pc = m_pc; e.instr = m_instr; e.mdr = m_mdr; e.a = m_a; e.b = m_b;
    e.ao = m_ao; e.cnt = m_cnt; e.mis = m_mis;
    sb.push_back(e);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [31:0] ares);
    drive(0, 0, 0, 0, 0, 2'd3, 2'd0, $urandom, ares, 0);
  endtask

  // Monitor: combinational outputs before the edge, registered outputs after it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (!$isunknown(e.pen))   chk("sb_pc_en", {31'd0, bus.pc_en}, {31'd0, e.pen});
        if (!$isunknown(e.maddr)) chk("sb_mem_addr", bus.mem_addr, e.maddr);
        @(posedge clk);
        #1;
        chk("sb_pc", bus.pc, e.pc);
        chk("sb_instr", bus.instr, e.instr);
        chk("sb_op", {26'd0, bus.op}, {26'd0, e.instr[31:26]});
        chk("sb_mdr", bus.mdr, e.mdr);
        chk("sb_reg_a", bus.reg_a, e.a);
        chk("sb_reg_b", bus.reg_b, e.b);
        chk("sb_alu_out", bus.alu_out, e.ao);
        chk("sb_count", bus.instr_count, e.cnt);
        chk("sb_misaligned", {31'd0, bus.pc_misaligned}, {31'd0, e.mis});
      end
    end
  end

  initial begin
    logic [31:0] rv, ares;
    bus.PCWriteCond = 0; bus.PCWrite = 0; bus.IRWrite = 0; bus.IorD = 0;
    bus.PCSource = PCSRC_HOLD; bus.ALUOp = ALUOP_ADD;
    bus.mem_rdata = 0; bus.alu_result = 0; bus.alu_zero = 0; bus.rd1 = 0; bus.rd2 = 0;

    drive(1, 0, 0, 0, 0, 2'd0, 2'd0, 32'h1234_5678, 32'h0, 0);
    drive(1, 0, 0, 0, 0, 2'd0, 2'd0, 32'h1234_5678, 32'h0, 0);
    after_edge();
    chk("reset_pc", bus.pc, 32'h0);
    chk("reset_instr", bus.instr, 32'h0);
    chk("reset_op", {26'd0, bus.op}, 32'h0);
    chk("reset_count", bus.instr_count, 32'h0);
    chk("reset_mis", {31'd0, bus.pc_misaligned}, 32'h0);

    drive(0, 0, 1, 1, 0, 2'd0, 2'd0, 32'h8C22_0010, 32'h4, 0);
    after_edge();
    chk("fetch_pc", bus.pc, 32'h4);
    chk("fetch_instr", bus.instr, 32'h8C22_0010);
    chk("fetch_op", {26'd0, bus.op}, {26'd0, OP_LW});
    chk("fetch_count", bus.instr_count, 32'h1);

    idle(32'h40);
    drive(0, 1, 0, 0, 0, 2'd1, 2'd1, 32'h0, 32'h40, 1);
    after_edge();
    chk("beq_taken_pc", bus.pc, 32'h40);
    drive(0, 1, 0, 0, 0, 2'd1, 2'd1, 32'h0, 32'h80, 0);
    #1 chk("beq_not_taken_pc_en", {31'd0, bus.pc_en}, 32'h0);
    after_edge();
    chk("beq_not_taken_pc", bus.pc, 32'h40);

    drive(0, 1, 0, 0, 0, 2'd1, 2'd3, 32'h0, 32'h80, 0);
    after_edge();
    chk("bne_taken_pc", bus.pc, 32'h80);
    drive(0, 1, 0, 0, 0, 2'd1, 2'd3, 32'h0, 32'hC0, 1);
    after_edge();
    chk("bne_not_taken_pc", bus.pc, 32'h80);

    drive(0, 0, 1, 0, 0, 2'd0, 2'd0, 32'h0, 32'h1000_0008, 0);
    drive(0, 0, 0, 1, 0, 2'd3, 2'd0, 32'h0800_0100, 32'h20, 0);
    drive(0, 0, 1, 0, 1, 2'd2, 2'd0, 32'h0, 32'h0, 0);
    #1 chk("iord_mem_addr", bus.mem_addr, 32'h20);
    after_edge();
    chk("jump_pc", bus.pc, 32'h1000_0400);

    drive(0, 0, 1, 0, 0, 2'd0, 2'd0, 32'h0, 32'h6, 0);
    after_edge();
    chk("misalign_pc", bus.pc, 32'h6);
    chk("misalign_set", {31'd0, bus.pc_misaligned}, 32'h1);
    drive(0, 0, 1, 0, 0, 2'd0, 2'd0, 32'h0, 32'h8, 0);
    after_edge();
    chk("misalign_sticky", {31'd0, bus.pc_misaligned}, 32'h1);
    drive(1, 0, 1, 1, 0, 2'd0, 2'd0, 32'hFFFF_FFFF, 32'h44, 0);
    after_edge();
    chk("midrst_pc", bus.pc, 32'h0);
    chk("midrst_mis", {31'd0, bus.pc_misaligned}, 32'h0);

    drive(0, 0, 1, 0, 0, 2'd0, 2'd0, 32'h0, 32'hFFFF_FFFC, 0);
    drive(0, 0, 1, 0, 0, 2'd0, 2'd0, 32'h0, 32'h0, 0);
    after_edge();
    chk("wrap_pc", bus.pc, 32'h0);
    chk("wrap_no_flag", {31'd0, bus.pc_misaligned}, 32'h0);

    for (int i = 0; i < 400; i++) begin
      rv = $urandom;
      ares = ($urandom_range(0, 7) == 0) ? rv : {rv[31:2], 2'b00};
      drive($urandom_range(0, 39) == 0, 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 2'($urandom), 2'($urandom), $urandom, ares, 1'($urandom));
    end
    after_edge();
    #5;
    chk("scoreboard_drained", sb.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
